stack_arbiter: RTL
==================

# stack_arbiter

Round-robin arbiter that shares one LIFO stack between N_REQ requesters. Each requester posts a push or pop request and holds it until it receives a one-cycle response. The arbiter serialises the requests into single-cycle push/pop strobes on the stack port and routes pop data back to the granted requester. It sits between the requester agents and the stack instance, and is the only driver of the stack's push/pop inputs.

## Interface
Parameters:
- N_REQ, default 4: number of requesters, minimum 2.
- WORD_LEN, default 8: data width; must match the stack's WORD_LEN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester request; held high until that requester's resp_valid bit.
- req_op  in  N_REQ  per-requester operation: 0 = push, 1 = pop.
- req_data  in  N_REQ*WORD_LEN  push data; requester i uses bits [i*WORD_LEN +: WORD_LEN].
- resp_valid  out  N_REQ  one-hot, one-cycle completion pulse.
- resp_data  out  WORD_LEN  pop result, shared bus; valid only while a resp_valid bit is high.
- resp_err  out  1  high with resp_valid when the op was refused (only with STACK_ARB_ERR_EN).
- busy  out  1  high in every state except S_IDLE.
- stk_push  out  1  to stack push.
- stk_pop  out  1  to stack pop.
- stk_data_in  out  WORD_LEN  to stack data_in.
- stk_data_out  in  WORD_LEN  from stack data_out; updated on the edge that ends a pop cycle.
- stk_full  in  1  from stack full.
- stk_empty  in  1  from stack empty.

## Operation
- FSM states are S_IDLE, S_ISSUE and S_RESP. The reset state is S_IDLE.
- Eligibility:
  - A push request is eligible when req_valid[i] is high and stk_full is low.
  - A pop request is eligible when req_valid[i] is high and stk_empty is low.
  - Error-path eligibility is defined under Configuration.
- S_IDLE:
  - If no request is eligible, the FSM stays in S_IDLE.
  - Otherwise the arbiter grants the first eligible index searching upward from last_grant+1, wrapping modulo N_REQ.
  - On the grant it registers grant_idx, op and data, and sets last_grant to grant_idx.
  - Next state is S_ISSUE.
- S_ISSUE:
  - Exactly one of stk_push or stk_pop is high, for exactly this one cycle.
  - stk_data_in equals the registered push data.
  - Next state is S_RESP.
- S_RESP:
  - resp_valid[grant_idx] is high for one cycle.
  - For a pop, resp_data is stk_data_out. For a push, resp_data is 0.
  - Next state is S_IDLE.
- stk_push and stk_pop are never high together, which keeps clear of the stack's simultaneous-op ignore rule.
- last_grant resets to N_REQ-1, so requester 0 has priority after reset.
- Once granted, the transaction completes whatever req_valid, req_op or req_data do afterwards.
- Requesters that are not eligible keep waiting. They are not dropped.

## Timing
- Reset values: all outputs 0, state S_IDLE, last_grant N_REQ-1. This applies both at power-up and when rstn asserts asynchronously mid-transaction.
- Reset mid-transaction aborts the transaction with no response. The stack is reset by the same rstn.
- Latency: a request eligible in cycle N (S_IDLE) drives the strobe in N+1 and produces resp_valid in N+2. The FSM is back in S_IDLE in N+3.
- Throughput is one operation per 3 cycles when requests are back to back.
- resp_data on a pop equals the element that was on top before the pop.
- A requester may deassert req_valid in the cycle after its resp_valid, or keep it high to issue another request. Another request is arbitrated from N+3 onward.
- Flags are sampled only in S_IDLE. Because the arbiter is the sole stack driver, the flags are stable there.

## Configuration
- Macro: STACK_ARB_ERR_EN.
- Defined:
  - A push while stk_full, or a pop while stk_empty, is also eligible.
  - It is granted in round-robin order like any other request.
  - S_ISSUE drives no strobe.
  - S_RESP pulses resp_valid[i] with resp_err=1 and resp_data=0.
- Not defined:
  - Such requests stay pending until the flag clears.
  - resp_err is tied to 0.
  - A pop pending on an empty stack with no pusher waits indefinitely; this is the intended behaviour.

## Test plan
- Reset, then requester 1 pushes 0x5A; then requester 1 pops:
  - Push: stk_push high one cycle, 1 cycle after the request; resp_valid=0b0010 two cycles after the request.
  - Pop: resp_data=0x5A, resp_err=0.
- Requesters 0, 1, 2 and 3 all push in the same cycle (0x10, 0x11, 0x12, 0x13), then requester 0 pops four times:
  - Grant order is 0, 1, 2, 3.
  - Pops return 0x13, 0x12, 0x11, 0x10.
- Fill the stack to 8 entries, then requester 2 pushes 0x77:
  - Macro off: no stk_push and no response until requester 3 pops, which returns the top entry; the 0x77 push then completes.
  - Macro on: resp_valid[2] with resp_err=1, and the stack is unchanged.
- Pop on an empty stack from requester 0:
  - Macro on: resp_err=1, resp_data=0.
  - Macro off: busy stays 0 while the stack is empty.
- Fairness: requesters 0 and 3 request continuously (push/pop alternating):
  - Grants alternate 0, 3, 0, 3.
  - No two consecutive grants go to the same requester while the other is eligible.
- Assert rstn low during S_ISSUE of a push:
  - All outputs are 0 immediately.
  - No resp_valid is produced.
  - After release, requester 0 has priority again.

Source files
------------

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter sharing one LIFO stack between N_REQ
// requesters. Each granted request becomes one push or pop strobe on the
// stack port, followed by a one-cycle response to the granted requester.
// Optional feature macro: STACK_ARB_ERR_EN. When it is defined, a push on a
// full stack or a pop on an empty stack is granted and answered with
// resp_err instead of waiting for the flag to clear.
module stack_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WORD_LEN = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_op,
  input  logic [N_REQ*WORD_LEN-1:0] req_data,
  output logic [N_REQ-1:0]          resp_valid,
  output logic [WORD_LEN-1:0]       resp_data,
  output logic                      resp_err,
  output logic                      busy,
  output logic                      stk_push,
  output logic                      stk_pop,
  output logic [WORD_LEN-1:0]       stk_data_in,
  input  logic [WORD_LEN-1:0]       stk_data_out,
  input  logic                      stk_full,
  input  logic                      stk_empty
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    last_grant;
  logic                grant_op;
  logic                grant_err;
  logic [WORD_LEN-1:0] grant_data;

  logic [N_REQ-1:0]    eligible;
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic                pick_err;
  logic [WORD_LEN-1:0] req_words [N_REQ];

  // Split the flat push-data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_words[i] = req_data[i*WORD_LEN +: WORD_LEN];
    end
  end

  // Decide which pending requests may be granted given the stack flags.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
`ifdef STACK_ARB_ERR_EN
      eligible[i] = req_valid[i];
`else
      eligible[i] = req_valid[i] && (req_op[i] ? !stk_empty : !stk_full);
`endif
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_grant;
    cand       = last_grant;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Flag a refused op at grant time; flags are stable while idle.
  always_comb begin
`ifdef STACK_ARB_ERR_EN
    pick_err = req_op[pick_idx] ? stk_empty : stk_full;
`else
    pick_err = 1'b0;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the winning request so later requester changes cannot disturb it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_idx  <= '0;
      grant_op   <= 1'b0;
      grant_err  <= 1'b0;
      grant_data <= '0;
      last_grant <= LAST_IDX;
    end else if (state == S_IDLE && pick_found) begin
      grant_idx  <= pick_idx;
      grant_op   <= req_op[pick_idx];
      grant_err  <= pick_err;
      grant_data <= req_words[pick_idx];
      last_grant <= pick_idx;
    end
  end

  // Next-state and output decode; every output is zero while idle.
  always_comb begin
    state_next  = state;
    resp_valid  = '0;
    resp_data   = '0;
    resp_err    = 1'b0;
    busy        = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = '0;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (!grant_err) begin
          stk_push = !grant_op;
          stk_pop  = grant_op;
          if (!grant_op) begin
            stk_data_in = grant_data;
          end
        end
        state_next = S_RESP;
      end
      S_RESP: begin
        busy       = 1'b1;
        resp_valid = ONE_HOT0 << grant_idx;
        resp_err   = grant_err;
        if (grant_op && !grant_err) begin
          resp_data = stk_data_out;
        end
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
